media_stream_scheduler: RTL and testbench



---
 rtl/media_stream_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_media_stream_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/media_stream_scheduler.sv
// Playback read sequencer: shares one SPI burst engine between the video bank
// writer and the audio FIFO, walking both flash streams with running addresses.
module media_stream_scheduler #(
  parameter logic [23:0] VIDEO_BASE        = 24'h000000,
  parameter logic [23:0] AUDIO_BASE        = 24'h800000,
  parameter int unsigned VIDEO_BLOCK_BYTES = 512,
  parameter int unsigned AUDIO_BLOCK_BYTES = 256,
  parameter int unsigned FRAME_BLOCKS      = 19,
  parameter int unsigned TOTAL_FRAMES      = 6572,
  parameter int unsigned AUDIO_BLOCKS      = 6572,
  parameter int unsigned FIFO_DEPTH        = 1024,
  parameter int unsigned AUDIO_LOW_WATER   = 256
) (
  input  logic        CLK_40,
  input  logic        reset_n,
  input  logic        start,
  input  logic        bank_full,
  input  logic [10:0] audio_level,
  output logic        spi_req_valid,
  input  logic        spi_req_ready,
  output logic [23:0] spi_req_addr,
  output logic [9:0]  spi_req_len,
  input  logic        spi_done,
  output logic        write_video,
  output logic        write_audio,
  output logic        frame_done,
  output logic        playing,
  output logic        finished,
  output logic        underrun
);

  localparam int unsigned FW = $clog2(TOTAL_FRAMES + 1);
  localparam int unsigned AW = $clog2(AUDIO_BLOCKS + 1);
  localparam int unsigned BW = $clog2(FRAME_BLOCKS + 1);
  localparam int unsigned LW = 11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ISSUE = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  logic [FW-1:0] r_frame_idx;
  logic [BW-1:0] r_video_blk;
  logic [AW-1:0] r_audio_cnt;
  logic [23:0]   r_vid_addr;
  logic [23:0]   r_aud_addr;
  logic          r_sel_audio;
  logic          r_req_valid;
  logic [23:0]   r_req_addr;
  logic [9:0]    r_req_len;
  logic          r_write_video;
  logic          r_write_audio;
  logic          r_frame_done;
  logic          r_playing;
  logic          r_finished;
  logic          r_underrun;

  logic w_aud_left;
  logic w_vid_left;
  logic w_aud_ok;
  logic w_aud_urgent;
  logic w_vid_ok;
  logic w_exhausted;
  logic w_underrun_set;

  // Stream eligibility, evaluated against live FIFO level and bank status
  assign w_aud_left     = r_audio_cnt < AW'(AUDIO_BLOCKS);
  assign w_vid_left     = r_frame_idx < FW'(TOTAL_FRAMES);
  assign w_aud_ok       = w_aud_left && (audio_level <= LW'(FIFO_DEPTH - AUDIO_BLOCK_BYTES));
  assign w_aud_urgent   = w_aud_ok && (audio_level < LW'(AUDIO_LOW_WATER));
  assign w_vid_ok       = w_vid_left && !bank_full;
  assign w_exhausted    = !w_vid_left && !w_aud_left;
  assign w_underrun_set = r_playing && (audio_level == '0) && w_aud_left;

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_frame_idx   <= '0;
      r_video_blk   <= '0;
      r_audio_cnt   <= '0;
      r_vid_addr    <= VIDEO_BASE;
      r_aud_addr    <= AUDIO_BASE;
      r_sel_audio   <= 1'b0;
      r_req_valid   <= 1'b0;
      r_req_addr    <= '0;
      r_req_len     <= '0;
      r_write_video <= 1'b0;
      r_write_audio <= 1'b0;
      r_frame_done  <= 1'b0;
      r_playing     <= 1'b0;
      r_finished    <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_underrun_set) r_underrun <= 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_frame_idx <= '0;
            r_video_blk <= '0;
            r_audio_cnt <= '0;
            r_vid_addr  <= VIDEO_BASE;
            r_aud_addr  <= AUDIO_BASE;
            r_underrun  <= 1'b0;
            r_playing   <= 1'b1;
            r_finished  <= 1'b0;
            r_state     <= S_ARB;
          end
        end

        // Urgent audio beats video, which beats non-urgent audio
        S_ARB: begin
          if (w_exhausted) begin
            r_playing  <= 1'b0;
            r_finished <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_aud_urgent || (w_aud_ok && !w_vid_ok)) begin
            r_sel_audio <= 1'b1;
            r_req_valid <= 1'b1;
            r_req_addr  <= r_aud_addr;
            r_req_len   <= 10'(AUDIO_BLOCK_BYTES);
            r_state     <= S_ISSUE;
          end else if (w_vid_ok) begin
            r_sel_audio <= 1'b0;
            r_req_valid <= 1'b1;
            r_req_addr  <= r_vid_addr;
            r_req_len   <= 10'(VIDEO_BLOCK_BYTES);
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (spi_req_ready) begin
            r_req_valid   <= 1'b0;
            r_write_audio <= r_sel_audio;
            r_write_video <= !r_sel_audio;
            r_state       <= S_XFER;
          end
        end

        S_XFER: begin
          if (spi_done) begin
            r_write_audio <= 1'b0;
            r_write_video <= 1'b0;
            r_state       <= S_ARB;
            if (r_sel_audio) begin
              r_aud_addr  <= r_aud_addr + 24'(AUDIO_BLOCK_BYTES);
              r_audio_cnt <= r_audio_cnt + AW'(1);
            end else begin
              r_vid_addr <= r_vid_addr + 24'(VIDEO_BLOCK_BYTES);
              if (r_video_blk == BW'(FRAME_BLOCKS - 1)) begin
                r_video_blk  <= '0;
                r_frame_idx  <= r_frame_idx + FW'(1);
                r_frame_done <= 1'b1;
              end else begin
                r_video_blk <= r_video_blk + BW'(1);
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi_req_valid = r_req_valid;
  assign spi_req_addr  = r_req_addr;
  assign spi_req_len   = r_req_len;
  assign write_video   = r_write_video;
  assign write_audio   = r_write_audio;
  assign frame_done    = r_frame_done;
  assign playing       = r_playing;
  assign finished      = r_finished;
  assign underrun      = r_underrun;

endmodule

// File: tb/tb_media_stream_scheduler.sv
// Directed bench for media_stream_scheduler with a shortened stream
// (2 frames of 19 video blocks, 3 audio blocks).
module tb_media_stream_scheduler;

  logic        CLK_40 = 1'b0;
  logic        reset_n;
  logic        start;
  logic        bank_full;
  logic [10:0] audio_level;
  logic        spi_req_valid;
  logic        spi_req_ready;
  logic [23:0] spi_req_addr;
  logic [9:0]  spi_req_len;
  logic        spi_done;
  logic        write_video;
  logic        write_audio;
  logic        frame_done;
  logic        playing;
  logic        finished;
  logic        underrun;

  int pass_cnt  = 0;
  int total_cnt = 0;

  media_stream_scheduler #(
    .TOTAL_FRAMES (2),
    .AUDIO_BLOCKS (3)
  ) dut (
    .CLK_40        (CLK_40),
    .reset_n       (reset_n),
    .start         (start),
    .bank_full     (bank_full),
    .audio_level   (audio_level),
    .spi_req_valid (spi_req_valid),
    .spi_req_ready (spi_req_ready),
    .spi_req_addr  (spi_req_addr),
    .spi_req_len   (spi_req_len),
    .spi_done      (spi_done),
    .write_video   (write_video),
    .write_audio   (write_audio),
    .frame_done    (frame_done),
    .playing       (playing),
    .finished      (finished),
    .underrun      (underrun)
  );

  always #12 CLK_40 = ~CLK_40;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK_40);
    #1;
  endtask

  // Waits (bounded) for a request, accepts it, completes it after dly cycles.
  task automatic get_burst(input int dly, output logic [23:0] a, output logic [9:0] l,
                           output logic wv, output logic wa, output logic fd,
                           output logic wl, output logic to);
    int n = 0;
    a = '0; l = '0; wv = 1'b0; wa = 1'b0; fd = 1'b0; wl = 1'b0; to = 1'b0;
    while (spi_req_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (spi_req_valid !== 1'b1) begin
      to = 1'b1;
      return;
    end
    a = spi_req_addr;
    l = spi_req_len;
    spi_req_ready = 1'b1;
    tick();
    spi_req_ready = 1'b0;
    wv = write_video;
    wa = write_audio;
    repeat (dly) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    fd = frame_done;
    wl = write_video | write_audio;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; bank_full = 1'b0; audio_level = 11'd1024;
    spi_req_ready = 1'b0; spi_done = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({spi_req_valid, write_video, write_audio, frame_done, playing, finished, underrun} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {spi_req_valid, write_video, write_audio, frame_done, playing, finished, underrun});
    else pass_cnt++;
    total_cnt++;
    if ({spi_req_addr, spi_req_len} !== 34'd0)
      $display("FAIL reset_req: got addr %h len %0d want 0/0", spi_req_addr, spi_req_len);
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_video_frame();
    logic [23:0] a; logic [9:0] l; logic wv, wa, fd, wl, to;
    start = 1'b1; tick(); start = 1'b0;
    total_cnt++;
    if (playing !== 1'b1 || finished !== 1'b0)
      $display("FAIL start_playing: got playing %b finished %b want 1 0", playing, finished);
    else pass_cnt++;
    for (int i = 0; i < 19; i++) begin
      get_burst(3, a, l, wv, wa, fd, wl, to);
      total_cnt++;
      if (to !== 1'b0 || a !== 24'(i * 512) || l !== 10'd512 || wv !== 1'b1 || wa !== 1'b0 ||
          wl !== 1'b0 || fd !== (i == 18))
        $display("FAIL video_burst_%0d: got to %b addr %h len %0d wv %b wa %b wl %b fd %b want 0 %h 512 1 0 0 %b",
                 i, to, a, l, wv, wa, wl, fd, 24'(i * 512), (i == 18));
      else pass_cnt++;
    end
  endtask

  task automatic test_audio_urgent();
    logic [23:0] a; logic [9:0] l; logic wv, wa, fd, wl, to;
    audio_level = 11'd100;
    tick();
    total_cnt++;
    if (frame_done !== 1'b0 || spi_req_valid !== 1'b1)
      $display("FAIL frame_done_pulse: got frame_done %b valid %b want 0 1", frame_done, spi_req_valid);
    else pass_cnt++;
    get_burst(3, a, l, wv, wa, fd, wl, to);
    total_cnt++;
    if (to !== 1'b0 || a !== 24'h800000 || l !== 10'd256 || wa !== 1'b1 || wv !== 1'b0 || wl !== 1'b0)
      $display("FAIL audio_urgent: got to %b addr %h len %0d wa %b wv %b wl %b want 0 800000 256 1 0 0",
               to, a, l, wa, wv, wl);
    else pass_cnt++;
  endtask

  task automatic test_no_eligible();
    logic [23:0] a; logic [9:0] l; logic wv, wa, fd, wl, to;
    logic seen;
    audio_level = 11'd900;
    bank_full   = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | spi_req_valid;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL no_eligible: got valid seen %b want 0", seen);
    else pass_cnt++;
    audio_level = 11'd700;
    get_burst(3, a, l, wv, wa, fd, wl, to);
    total_cnt++;
    if (to !== 1'b0 || a !== 24'h800100 || l !== 10'd256 || wa !== 1'b1 || wv !== 1'b0)
      $display("FAIL audio_nonurgent: got to %b addr %h len %0d wa %b wv %b want 0 800100 256 1 0",
               to, a, l, wa, wv);
    else pass_cnt++;
  endtask

  task automatic test_ready_stall();
    logic [23:0] a; logic [9:0] l; logic wv, wa, fd, wl, to;
    int n = 0;
    logic stable;
    audio_level = 11'd1024;
    bank_full   = 1'b0;
    while (spi_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (spi_req_valid !== 1'b1 || spi_req_addr !== 24'h002600 || spi_req_len !== 10'd512)
        stable = 1'b0;
      tick();
    end
    total_cnt++;
    if (stable !== 1'b1 || write_video !== 1'b0)
      $display("FAIL ready_stall: got stable %b write_video %b want 1 0", stable, write_video);
    else pass_cnt++;
    get_burst(3, a, l, wv, wa, fd, wl, to);
    total_cnt++;
    if (to !== 1'b0 || a !== 24'h002600 || wv !== 1'b1 || fd !== 1'b0)
      $display("FAIL stall_accept: got to %b addr %h wv %b fd %b want 0 002600 1 0", to, a, wv, fd);
    else pass_cnt++;
    // stray done pulses in ARB and ISSUE must not advance anything
    spi_done = 1'b1; tick(); spi_done = 1'b0;
    spi_done = 1'b1; tick(); spi_done = 1'b0;
    total_cnt++;
    if (spi_req_valid !== 1'b1 || spi_req_addr !== 24'h002800 || write_video !== 1'b0)
      $display("FAIL spurious_done: got valid %b addr %h wv %b want 1 002800 0",
               spi_req_valid, spi_req_addr, write_video);
    else pass_cnt++;
    get_burst(3, a, l, wv, wa, fd, wl, to);
    total_cnt++;
    if (to !== 1'b0 || a !== 24'h002800 || wv !== 1'b1)
      $display("FAIL after_spurious: got to %b addr %h wv %b want 0 002800 1", to, a, wv);
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [23:0] a; logic [9:0] l; logic wv, wa, fd, wl, to;
    total_cnt++;
    if (underrun !== 1'b0) $display("FAIL underrun_clear: got %b want 0", underrun);
    else pass_cnt++;
    audio_level = 11'd0;
    tick();
    total_cnt++;
    if (underrun !== 1'b1) $display("FAIL underrun_set: got %b want 1", underrun);
    else pass_cnt++;
    audio_level = 11'd1024;
    get_burst(3, a, l, wv, wa, fd, wl, to);
    total_cnt++;
    if (to !== 1'b0 || a !== 24'h800200 || wa !== 1'b1 || underrun !== 1'b1)
      $display("FAIL underrun_hold: got to %b addr %h wa %b underrun %b want 0 800200 1 1",
               to, a, wa, underrun);
    else pass_cnt++;
  endtask

  task automatic test_exhaust();
    logic [23:0] a; logic [9:0] l; logic wv, wa, fd, wl, to;
    for (int i = 0; i < 17; i++) begin
      get_burst(2, a, l, wv, wa, fd, wl, to);
      total_cnt++;
      if (to !== 1'b0 || a !== 24'(24'h002A00 + i * 512) || wv !== 1'b1 || wa !== 1'b0 || fd !== (i == 16))
        $display("FAIL frame1_burst_%0d: got to %b addr %h wv %b wa %b fd %b want 0 %h 1 0 %b",
                 i, to, a, wv, wa, fd, 24'(24'h002A00 + i * 512), (i == 16));
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (finished !== 1'b1 || playing !== 1'b0 || spi_req_valid !== 1'b0)
      $display("FAIL exhausted: got finished %b playing %b valid %b want 1 0 0",
               finished, playing, spi_req_valid);
    else pass_cnt++;
    repeat (5) tick();
    total_cnt++;
    if (finished !== 1'b1 || spi_req_valid !== 1'b0 || underrun !== 1'b1)
      $display("FAIL done_idle: got finished %b valid %b underrun %b want 1 0 1",
               finished, spi_req_valid, underrun);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    logic [23:0] a; logic [9:0] l; logic wv, wa, fd, wl, to;
    start = 1'b1; tick(); start = 1'b0;
    total_cnt++;
    if (playing !== 1'b1 || finished !== 1'b0 || underrun !== 1'b0)
      $display("FAIL restart_flags: got playing %b finished %b underrun %b want 1 0 0",
               playing, finished, underrun);
    else pass_cnt++;
    get_burst(3, a, l, wv, wa, fd, wl, to);
    total_cnt++;
    if (to !== 1'b0 || a !== 24'h000000 || wv !== 1'b1)
      $display("FAIL restart_addr: got to %b addr %h wv %b want 0 000000 1", to, a, wv);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_xfer();
    logic [23:0] a; logic [9:0] l; logic wv, wa, fd, wl, to;
    int n = 0;
    while (spi_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    spi_req_ready = 1'b1; tick(); spi_req_ready = 1'b0;
    total_cnt++;
    if (write_video !== 1'b1 || spi_req_addr !== 24'h000200)
      $display("FAIL pre_reset_xfer: got wv %b addr %h want 1 000200", write_video, spi_req_addr);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (write_video !== 1'b0 || playing !== 1'b0 || spi_req_valid !== 1'b0)
      $display("FAIL async_reset: got wv %b playing %b valid %b want 0 0 0",
               write_video, playing, spi_req_valid);
    else pass_cnt++;
    #2 reset_n = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if (playing !== 1'b0 || spi_req_valid !== 1'b0)
      $display("FAIL no_resume: got playing %b valid %b want 0 0", playing, spi_req_valid);
    else pass_cnt++;
    start = 1'b1; tick(); start = 1'b0;
    get_burst(3, a, l, wv, wa, fd, wl, to);
    total_cnt++;
    if (to !== 1'b0 || a !== 24'h000000 || wv !== 1'b1)
      $display("FAIL post_reset_addr: got to %b addr %h wv %b want 0 000000 1", to, a, wv);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_video_frame();
    test_audio_urgent();
    test_no_eligible();
    test_ready_stall();
    test_underrun();
    test_exhaust();
    test_restart();
    test_reset_mid_xfer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
